nibble_serial_add_ctrl: RTL and testbench
=========================================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 Ports, one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- A  input  W  operand A; captured on the accept edge.
- B  input  W  operand B; captured on the accept edge.
- C_in  input  1  carry-in; captured on the accept edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- S  output  W  registered sum.
- C_out  output  1  registered carry-out of the MSB nibble.
- ovf  output  1  registered two's-complement overflow of the W-bit add.

Function
REQ-003 The block SHALL compute {C_out,S} = A + B + C_in using one 4-bit add per clock, LSB nibble first, with a registered inter-nibble carry.
REQ-004 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-005 IDLE with start=1 at a rising edge (the accept edge) SHALL latch A, B and C_in into internal registers, clear the nibble counter to 0, load the carry register with C_in, and enter RUN.
REQ-006 In IDLE with start=0, the FSM SHALL remain in IDLE with all outputs held.
REQ-007 In RUN, each edge SHALL add nibble[cnt] of the latched A and B plus the carry register, store the 4-bit sum into slice cnt of an internal result register, update the carry register, and increment cnt.
REQ-008 On the edge that processes cnt = NIBBLES-1, the FSM SHALL:
- copy the internal result to S;
- copy the final carry to C_out;
- set ovf = (A[W-1]==B[W-1]) && (S[W-1]!=A[W-1]), using the latched operands;
- enter DONE.
REQ-009 done SHALL be high only in DONE, which lasts exactly one cycle and then returns to IDLE.
REQ-010 Latency: done SHALL be high in the cycle following edge NIBBLES after the accept edge (edge 4 for the default).
REQ-011 Throughput: a new start SHALL be accepted no earlier than the IDLE cycle after DONE, so the back-to-back period is NIBBLES+2 cycles.
REQ-012 Any start asserted in RUN or DONE SHALL be ignored and not queued.
REQ-013 Changes on A, B and C_in after the accept edge SHALL NOT affect the result in progress.
REQ-014 S, C_out and ovf SHALL change only on the final RUN edge, and SHALL hold their values through DONE and IDLE until the next completion.
REQ-015 The counter SHALL be wide enough to index NIBBLES slices and SHALL NOT wrap in RUN; reaching NIBBLES-1 always exits RUN.
REQ-016 The arithmetic SHALL be unsigned modulo 2^W, with the carry out of bit W-1 reported on C_out; ovf is informational only.

Reset
REQ-017 When rst_n=0, asynchronously and regardless of state, the FSM SHALL go to IDLE, and the following SHALL be cleared to 0: busy, done, S, C_out, ovf, cnt, the carry register and all operand/result registers.
REQ-018 A reset during RUN SHALL abort the operation; no done pulse is produced for it.
REQ-019 After rst_n deasserts, the block SHALL accept start on the first rising edge where rst_n=1 and start=1.

Verification
REQ-020 Start, A=0x0000, B=0x0000, C_in=0 -> busy high for 5 cycles; done pulses 1 cycle after edge 4; S=0x0000, C_out=0, ovf=0.
REQ-021 A=0xABCD, B=0x1234, C_in=1 -> S=0xBE02, C_out=0, ovf=0; operands changed to 0xFFFF one cycle after accept -> result unchanged.
REQ-022 Carry ripple and overflow:
- A=0xFFFF, B=0x0001, C_in=0 -> S=0x0000, C_out=1, ovf=0.
- Then A=0x7FFF, B=0x0001, C_in=0 -> S=0x8000, C_out=0, ovf=1.
REQ-023 Extreme operands with held request: A=0xFFFF, B=0xFFFF, C_in=1 -> S=0xFFFF, C_out=1, ovf=0; start held high throughout -> second operation accepted only in the IDLE cycle after done, giving a period of 6 cycles.
REQ-024 rst_n pulsed low after edge 2 of an operation -> busy=0, S=0, C_out=0 immediately, no done pulse; a subsequent start with A=0x0001, B=0x0002, C_in=0 -> S=0x0003.
REQ-025 NIBBLES=2 build: A=0xF0, B=0x10, C_in=0 -> S=0x00, C_out=1, ovf=0, done 1 cycle after edge 2.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller: adds two W-bit operands plus a carry-in
// using one 4-bit addition per clock, LSB nibble first. A three-state FSM
// (IDLE/RUN/DONE) sequences the slices; S, C_out and ovf are registered and
// change only on the final RUN edge.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   C_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   S,
    output logic                   C_out,
    output logic                   ovf
);

    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     res_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [W-1:0]     s_q;
    logic             cout_q;
    logic             ovf_q;

    logic [CNT_W+1:0] shift_d;
    logic [W-1:0]     a_sh_d;
    logic [W-1:0]     b_sh_d;
    logic [4:0]       sum_d;
    logic [W-1:0]     res_d;
    logic             ovf_d;

    // 4-bit add with carry-in; bit 4 of the result is the nibble carry-out.
    function automatic logic [4:0] nib_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic ci);
        return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    endfunction

    // Current slice arithmetic: select nibble cnt, add, and merge into the result.
    always_comb begin
        shift_d = {cnt_q, 2'b00};
        a_sh_d  = a_q >> shift_d;
        b_sh_d  = b_q >> shift_d;
        sum_d   = nib_add(a_sh_d[3:0], b_sh_d[3:0], carry_q);
        res_d   = (res_q & ~(W'(4'hF) << shift_d)) | (W'(sum_d[3:0]) << shift_d);
        // Overflow judged on the fully assembled result, so only meaningful on the last slice.
        ovf_d   = (a_q[W-1] == b_q[W-1]) && (res_d[W-1] != a_q[W-1]);
    end

    // Control FSM with registered outputs; reset clears every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= C_in;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= sum_d[4];
                    if (cnt_q == LAST_CNT) begin
                        // Final slice: publish the result; the counter stays put so it never wraps.
                        s_q     <= res_d;
                        cout_q  <= sum_d[4];
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    // Start is ignored here; the next request is taken from IDLE.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign S     = s_q;
    assign C_out = cout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl: default 4-nibble build plus a
// 2-nibble build sharing clock and reset.
module tb_nibble_serial_add_ctrl;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        C_in;
    logic        busy;
    logic        done;
    logic [15:0] S;
    logic        C_out;
    logic        ovf;

    logic        start2;
    logic [7:0]  A2;
    logic [7:0]  B2;
    logic        C_in2;
    logic        busy2;
    logic        done2;
    logic [7:0]  S2;
    logic        C_out2;
    logic        ovf2;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    exp_t exp_q[$];

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .C_in(C_in),
        .busy(busy), .done(done), .S(S), .C_out(C_out), .ovf(ovf)
    );

    nibble_serial_add_ctrl #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .A(A2), .B(B2), .C_in(C_in2),
        .busy(busy2), .done(done2), .S(S2), .C_out(C_out2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci);
        logic [16:0] t;
        exp_t e;
        t   = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
        e.s = t[15:0];
        e.c = t[16];
        e.o = (a[15] == b[15]) && (t[15] != a[15]);
        return e;
    endfunction

    // Scoreboard: every done pulse pops one expected result and checks latency.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("S", S, e.s);
                chk("C_out", C_out, e.c);
                chk("ovf", ovf, e.o);
                chk("latency", cyc - acc_cyc, 4);
            end
        end
    end

    task automatic wait_idle(output int nb);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci);
        int   nb;
        exp_t e;
        e = model(a, b, ci);
        @(negedge clk);
        start = 1'b1; A = a; B = b; C_in = ci;
        exp_q.push_back(e);
        @(negedge clk);
        acc_cyc = cyc;
        // Scramble operands after the accept edge; the result must not move.
        start = 1'b0; A = 16'hFFFF; B = 16'hFFFF; C_in = 1'b1;
        wait_idle(nb);
        chk("busy_cycles", nb, 5);
        chk("pending", exp_q.size(), 0);
        chk("S_hold", S, e.s);
        chk("C_out_hold", C_out, e.c);
    endtask

    task automatic run2(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        start2 = 1'b1; A2 = a; B2 = b; C_in2 = ci;
        @(negedge clk);
        start2 = 1'b0; A2 = 8'hFF; B2 = 8'hFF; C_in2 = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (done2) break;
            lat++;
            @(negedge clk);
        end
        chk("n2_latency", lat, 2);
        chk("n2_S", S2, es);
        chk("n2_C_out", C_out2, ec);
        chk("n2_ovf", ovf2, eo);
        repeat (2) @(negedge clk);
        chk("n2_idle", busy2, 0);
    endtask

    initial begin
        int   nb;
        bit   seen;
        exp_t e;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; C_in = 1'b0;
        start2 = 1'b0; A2 = '0; B2 = '0; C_in2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_S", S, 0);
        chk("rst_C_out", C_out, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        run_op(16'h0000, 16'h0000, 1'b0);
        run_op(16'hABCD, 16'h1234, 1'b1);
        run_op(16'hFFFF, 16'h0001, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0);

        // Start held high: second accept only in the IDLE cycle after done.
        e = model(16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; C_in = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(e);
        @(negedge clk);
        acc_cyc = cyc;
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            @(negedge clk);
        end
        @(negedge clk);
        acc_cyc = acc_cyc + 6;
        @(negedge clk);
        chk("held_reaccept_busy", busy, 1);
        start = 1'b0; A = 16'h0000; B = 16'h0000; C_in = 1'b0;
        wait_idle(nb);
        chk("held_pending", exp_q.size(), 0);
        chk("held_S", S, 16'hFFFF);

        // Reset after edge 2 of an operation aborts it without a done pulse.
        @(negedge clk);
        start = 1'b1; A = 16'h1234; B = 16'h1111; C_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_S", S, 0);
        chk("abort_C_out", C_out, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        run_op(16'h0001, 16'h0002, 1'b0);

        run2(8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
        run2(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
